// File: rtl/logic_gate_pkg.sv
// Shared types for the pipelined bitwise logic unit: opcode encoding and the
// per-beat flag bundle that travels with every result.
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  // Width-independent tail of the beat; the instantiating module prepends y[WIDTH-1:0].
  typedef struct packed {
    logic y_zero;
    logic y_ones;
    logic op_err;
  } beat_flags_t;

  function automatic logic op_is_reserved(input op_e op);
    return (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Operand/result stream bundle for logic_gate_pipe; the producer/consumer side
// uses the master modport, the unit itself uses slave.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;
  logic             op_err;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones, op_err, xfer_cnt
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones, op_err, xfer_cnt
  );
endinterface

// File: rtl/logic_gate_skid.sv
// One-entry skid buffer in front of an output register. in_ready is the
// registered inverse of the skid-full bit, so it never depends on out_ready.
module logic_gate_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_full_q, skid_full_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept, xfer;

  assign accept = in_valid && !skid_full_q;
  assign xfer   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    if (skid_full_q) begin
      // Skid only fills while the output is held, so draining it keeps out_valid high.
      if (xfer) begin
        out_data_d  = skid_data_q;
        skid_full_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || xfer) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d = in_data;
        skid_full_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = !skid_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined two-operand bitwise logic unit: decodes op, derives zero/ones/error
// flags, buffers the beat through logic_gate_skid and counts output transfers.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  logic_gate_pipe_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    beat_flags_t      flags;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  logic [WIDTH-1:0] res_y;
  logic             res_err;
  op_e              op_dec;
  beat_t            res_beat;
  beat_t            out_beat;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  assign op_dec = op_e'(bus.op);

  always_comb begin
    res_y   = '0;
    res_err = op_is_reserved(op_dec);
    unique case (op_dec)
      OP_AND:    res_y = bus.a & bus.b;
      OP_OR:     res_y = bus.a | bus.b;
      OP_XOR:    res_y = bus.a ^ bus.b;
      OP_NAND:   res_y = ~(bus.a & bus.b);
      OP_NOR:    res_y = ~(bus.a | bus.b);
      OP_XNOR:   res_y = ~(bus.a ^ bus.b);
      OP_PASS_A: res_y = bus.a;
      default:   res_y = '0;
    endcase
  end

  // Flags are computed before the register so they stay aligned with y.
  always_comb begin
    res_beat              = '0;
    res_beat.y            = res_y;
    res_beat.flags.y_zero = (res_y == '0);
    res_beat.flags.y_ones = (res_y == '1);
    res_beat.flags.op_err = res_err;
  end

  logic_gate_skid #(
    .DATA_W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (res_beat),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_beat)
  );

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (bus.out_valid && bus.out_ready) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign bus.y        = out_beat.y;
  assign bus.y_zero   = out_beat.flags.y_zero;
  assign bus.y_ones   = out_beat.flags.y_ones;
  assign bus.op_err   = out_beat.flags.op_err;
  assign bus.xfer_cnt = xfer_cnt_q;

endmodule
